// File: rtl/ex_muldiv_sequencer_if.sv
// Handshake bundle between the EX stage pipeline and the iterative mul/div sequencer.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface ex_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, op, opA, opB, flush,
        input  stall, busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, opA, opB, flush,
        output stall, busy, done, result, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Iterative MUL/MULH/DIV/REM sequencer sharing one 32-step shift-add / restoring-divide datapath.
// Define MULDIV_SIGNED_EN for two's complement operands (magnitude datapath plus sign fix-up on result load).
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result_q;
    logic             dbz_q;

    logic             accept;
    logic             step_en;
    logic             stall_c;
    logic             busy_c;
    logic             done_c;
    logic             div_zero_in;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] zero_result;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;
    logic [WIDTH-1:0] run_result;

    assign div_zero_in = bus.op[1] && (bus.opB == '0);
    assign zero_result = bus.op[0] ? bus.opA : '1;

`ifdef MULDIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_main_q;
    logic neg_rem_q;

    assign a_neg = bus.opA[WIDTH-1];
    assign b_neg = bus.opB[WIDTH-1];
    assign a_mag = a_neg ? -bus.opA : bus.opA;
    assign b_mag = b_neg ? -bus.opB : bus.opB;

    // Product/quotient sign follows the operand sign mismatch; remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            neg_main_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
        end
    end
`else
    assign a_mag = bus.opA;
    assign b_mag = bus.opB;
`endif

    // acc_hi holds the product high word / partial remainder, acc_lo the multiplier / dividend-quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, operand};
        div_diff  = div_shift[WIDTH-1:0] - operand;
        if (op_q[1]) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        fin_hi = step_hi;
        fin_lo = step_lo;
`ifdef MULDIV_SIGNED_EN
        if (!op_q[1]) begin
            if (neg_main_q) begin
                {fin_hi, fin_lo} = -{step_hi, step_lo};
            end
        end else begin
            if (neg_main_q) begin
                fin_lo = -step_lo;
            end
            if (neg_rem_q) begin
                fin_hi = -step_hi;
            end
        end
`endif
        run_result = op_q[0] ? fin_hi : fin_lo;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step_en    = 1'b0;
        stall_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept     = 1'b1;
                    stall_c    = 1'b1;
                    state_next = div_zero_in ? DONE : RUN;
                end
            end
            RUN: begin
                busy_c  = 1'b1;
                stall_c = 1'b1;
                if (bus.flush) begin
                    state_next = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (count == '0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // start is ignored here: ID/EX still holds the instruction that just finished.
                done_c     = !bus.flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            stall_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q    <= bus.op;
                count   <= CW'(WIDTH - 1);
                acc_hi  <= '0;
                acc_lo  <= bus.op[1] ? a_mag : b_mag;
                operand <= bus.op[1] ? b_mag : a_mag;
                if (div_zero_in) begin
                    result_q <= zero_result;
                    dbz_q    <= 1'b1;
                end
            end else if (step_en) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count - CW'(1);
                if (count == '0) begin
                    result_q <= run_result;
                    dbz_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: vector table plus hand-written flush/back-to-back sequences.
// Expected values follow the MULDIV_SIGNED_EN build setting.
module tb_ex_muldiv_sequencer;
    localparam int W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] result;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] result;
        logic         dbz;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [W-1:0] last_res;

    vec_t vecs[$];
    exp_t exp_q[$];

    ex_muldiv_sequencer_if #(.WIDTH(W)) bus ();

    ex_muldiv_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference model built from native wide arithmetic; returns {dbz, result}.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
`ifdef MULDIV_SIGNED_EN
        p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
`else
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
`endif
        case (o)
            2'b00:   return {1'b0, p[W-1:0]};
            2'b01:   return {1'b0, p[2*W-1:W]};
            2'b10:   return {(b == '0), q};
            default: return {(b == '0), r};
        endcase
    endfunction

    task automatic add_vec(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] r, input logic d);
        vecs.push_back('{op: o, a: a, b: b, result: r, dbz: d});
    endtask

    task automatic check_output(input int cyc);
        exp_t e;
        e = exp_q.pop_front();
        cmp("result", bus.result, e.result);
        cmp("div_by_zero", bus.div_by_zero, e.dbz);
        cmp("latency", cyc, e.lat);
        cmp("stall_in_done", bus.stall, 0);
        last_res = e.result;
    endtask

    // Drives one op from IDLE, holds start until done, checks stall each cycle; returns in the DONE cycle.
    task automatic apply_stimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] r, input logic d);
        exp_t e;
        int   cyc;
        bit   got;
        bit   stall_bad;
        e.result = r;
        e.dbz    = d;
        e.lat    = (o[1] && b == '0) ? 1 : W + 1;
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.op    = o;
        bus.opA   = a;
        bus.opB   = b;
        #1;
        cmp("accept_stall", bus.stall, 1);
        cyc       = 0;
        got       = 0;
        stall_bad = 0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) got = 1;
            else if (!bus.stall) stall_bad = 1;
        end
        bus.start = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL done_timeout: actual no done after %0d cycles required done", cyc);
            void'(exp_q.pop_front());
        end else begin
            cmp("stall_while_running", stall_bad, 0);
            check_output(cyc);
        end
    endtask

    initial begin
        int done_seen;
        n_cmp     = 0;
        n_bad     = 0;
        last_res  = '0;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opA   = 32'd7;
        bus.opB   = 32'd6;
        bus.flush = 1'b0;

        // Vectors valid in both builds.
        add_vec(2'b00, 32'd7, 32'd6, 32'd42, 1'b0);
        add_vec(2'b10, 32'd100, 32'd7, 32'd14, 1'b0);
        add_vec(2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
        add_vec(2'b10, 32'd7, 32'd100, 32'd0, 1'b0);
        add_vec(2'b11, 32'd7, 32'd100, 32'd7, 1'b0);
        add_vec(2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        add_vec(2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
        add_vec(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
`ifdef MULDIV_SIGNED_EN
        add_vec(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        add_vec(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        add_vec(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        add_vec(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        add_vec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
        add_vec(2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
        add_vec(2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
`else
        add_vec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        add_vec(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        add_vec(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        add_vec(2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        add_vec(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0);
`endif
        for (int i = 0; i < 6; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W:0]   m;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            m = model(o, a, b);
            add_vec(o, a, b, m[W-1:0], m[W]);
        end

        // Reset held with start asserted: outputs stay at reset values.
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_stall", bus.stall, 0);
        cmp("rst_busy", bus.busy, 0);
        cmp("rst_done", bus.done, 0);
        cmp("rst_result", bus.result, 0);
        cmp("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        #1;
        cmp("release_stall", bus.stall, 1);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        cmp("idle_busy", bus.busy, 0);

        // Table-driven vectors, each followed by a check that done was a single-cycle pulse.
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].result, vecs[i].dbz);
            @(posedge clk);
            #1;
            cmp("after_done_done", bus.done, 0);
            cmp("after_done_busy", bus.busy, 0);
        end

        // Flush at cycle 10 of a DIV: abandon, no done, result untouched.
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.opA   = 32'd1000;
        bus.opB   = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        cmp("flush_run_busy", bus.busy, 1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        cmp("flush_idle_busy", bus.busy, 0);
        cmp("flush_idle_stall", bus.stall, 0);
        cmp("flush_idle_done", bus.done, 0);
        cmp("flush_result_kept", bus.result, last_res);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        cmp("flush_no_done", done_seen, 0);

        // Flush in the DONE cycle: done suppressed but result still loaded.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opA   = 32'd3;
        bus.opB   = 32'd5;
        repeat (W + 1) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        #1;
        cmp("flush_done_done", bus.done, 0);
        cmp("flush_done_stall", bus.stall, 0);
        cmp("flush_done_result", bus.result, 15);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        cmp("flush_done_idle", bus.busy, 0);
        last_res = 32'd15;

        // Back-to-back: the next op is presented during DONE and must be accepted in the following cycle.
        apply_stimulus(2'b00, 32'd7, 32'd6, 32'd42, 1'b0);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.opA   = 32'd100;
        bus.opB   = 32'd7;
        @(posedge clk);
        #1;
        apply_stimulus(2'b10, 32'd100, 32'd7, 32'd14, 1'b0);
        @(posedge clk);
        #1;

        // Reset mid-operation returns to IDLE with reset-valued outputs.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.opA   = 32'd9;
        bus.opB   = 32'd9;
        repeat (5) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.start = 1'b0;
        #1;
        cmp("midrst_stall", bus.stall, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp("midrst_busy", bus.busy, 0);
        cmp("midrst_result", bus.result, 0);
        cmp("midrst_dbz", bus.div_by_zero, 0);

        cmp("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
